// File: rtl/riscv_mem_pkg.sv
// ============================================================================
// Module      : riscv_mem_pkg
// Description : Shared definitions for the data-memory responder: RISC-V
//               load/store funct3 encodings and the responder FSM state type.
// Ports       : none (package)
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_mem_pkg;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : riscv_mem_pkg

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational lane steering for byte/half/word accesses.
//               Produces store byte-enables and the merged store word, the
//               sign/zero-extended load value and the access error flag.
// Ports       : i_we      - 1 = store, 0 = load
//               i_funct3  - RISC-V load/store funct3
//               i_addr    - byte lane (address bits [1:0])
//               i_wdata   - right-aligned store data
//               i_rword   - current contents of the addressed word
//               o_be      - byte enables (all zero for loads and errors)
//               o_wmerged - word to write back (enabled lanes replaced)
//               o_load    - extended load value (zero for stores / errors)
//               o_err     - invalid funct3, or misaligned when trapping
// Config      : MISALIGN_TRAP_EN - defined: misaligned half/word accesses
//               raise o_err; undefined: address is forced aligned.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wmerged,
    output logic [31:0] o_load,
    output logic        o_err
);

    logic        w_is_half;
    logic        w_is_word;
    logic        w_f3_bad;
    logic        w_misalign;
    logic [1:0]  w_lane;
    logic [31:0] w_shift;
    logic [31:0] w_wrep;
    logic [3:0]  w_be_raw;

    // funct3[1:0] encodes the size for both loads and stores
    assign w_is_half = (i_funct3[1:0] == 2'b01);
    assign w_is_word = (i_funct3[1:0] == 2'b10);

    // Stores only support 000/001/010; loads additionally 100/101
    assign w_f3_bad = i_we ? (i_funct3[2] || (i_funct3[1:0] == 2'b11))
                           : ((i_funct3[1:0] == 2'b11) ||
                              (i_funct3[2] && i_funct3[1]));

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (w_is_half && i_addr[0]) ||
                        (w_is_word && (i_addr != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign o_err = w_f3_bad || w_misalign;

    // Force natural alignment; when trapping the access is suppressed anyway
    always_comb begin
        w_lane = i_addr;
        if (w_is_half) begin
            w_lane = {i_addr[1], 1'b0};
        end else if (w_is_word) begin
            w_lane = 2'b00;
        end
    end

    assign w_shift = i_rword >> {w_lane, 3'b000};

    always_comb begin
        o_load = 32'h0;
        if (!i_we && !o_err) begin
            case (i_funct3)
                F3_LB:   o_load = {{24{w_shift[7]}}, w_shift[7:0]};
                F3_LH:   o_load = {{16{w_shift[15]}}, w_shift[15:0]};
                F3_LW:   o_load = w_shift;
                F3_LBU:  o_load = {24'h0, w_shift[7:0]};
                F3_LHU:  o_load = {16'h0, w_shift[15:0]};
                default: o_load = 32'h0;
            endcase
        end
    end

    // Replicate store data across all lanes; byte-enables pick the target
    always_comb begin
        w_wrep   = i_wdata;
        w_be_raw = 4'b0000;
        case (i_funct3)
            F3_SB: begin
                w_wrep   = {4{i_wdata[7:0]}};
                w_be_raw = 4'b0001 << w_lane;
            end
            F3_SH: begin
                w_wrep   = {2{i_wdata[15:0]}};
                w_be_raw = 4'b0011 << w_lane;
            end
            F3_SW: begin
                w_wrep   = i_wdata;
                w_be_raw = 4'b1111;
            end
            default: begin
                w_wrep   = i_wdata;
                w_be_raw = 4'b0000;
            end
        endcase
    end

    assign o_be = (i_we && !o_err) ? w_be_raw : 4'b0000;

    always_comb begin
        o_wmerged = i_rword;
        for (int i = 0; i < 4; i++) begin
            if (o_be[i]) begin
                o_wmerged[i*8 +: 8] = w_wrep[i*8 +: 8];
            end
        end
    end

endmodule : mem_lane_align

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : Memory end of the core's load/store interface. Accepts one
//               request at a time, waits LATENCY+1 cycles, performs the
//               access on an internal word-organised RAM and returns the
//               result over a valid/ready response channel.
// Ports       : clk, rst                  - clock, async active-high reset
//               req_valid/req_ready       - request handshake
//               req_we, req_addr,
//               req_funct3, req_wdata     - request payload
//               rsp_valid/rsp_ready       - response handshake
//               rsp_rdata, rsp_err        - response payload
// Config      : MISALIGN_TRAP_EN - misaligned half/word accesses return
//               rsp_err instead of being forced aligned.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int C_IDX_W = $clog2(DEPTH_WORDS);
    localparam int C_ADR_W = C_IDX_W + 2;
    localparam int C_CNT_W = $clog2(LATENCY + 2);
    localparam logic [C_CNT_W-1:0] C_CNT_INIT =
        (LATENCY > 0) ? C_CNT_W'(LATENCY - 1) : '0;

    state_t               r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_we;
    logic [C_ADR_W-1:0]   r_addr;
    logic [2:0]           r_funct3;
    logic [31:0]          r_wdata;
    logic                 r_rsp_valid;
    logic [31:0]          r_rdata;
    logic                 r_err;

    logic [31:0]          r_mem [DEPTH_WORDS];

    logic                 w_cur_we;
    logic [C_ADR_W-1:0]   w_cur_addr;
    logic [2:0]           w_cur_funct3;
    logic [31:0]          w_cur_wdata;
    logic [C_IDX_W-1:0]   w_cur_idx;
    logic [31:0]          w_rword;
    logic [3:0]           w_be;
    logic [31:0]          w_wmerged;
    logic [31:0]          w_load;
    logic                 w_err;
    logic                 w_enter_resp;
    logic                 w_commit;
    logic                 w_unused_addr;

    // With LATENCY=0 the access happens on the acceptance edge, so the
    // aligner must see the live request while idle and the captured one after.
    assign w_cur_we     = (r_state == IDLE) ? req_we                : r_we;
    assign w_cur_addr   = (r_state == IDLE) ? req_addr[C_ADR_W-1:0] : r_addr;
    assign w_cur_funct3 = (r_state == IDLE) ? req_funct3            : r_funct3;
    assign w_cur_wdata  = (r_state == IDLE) ? req_wdata             : r_wdata;
    assign w_cur_idx    = w_cur_addr[C_ADR_W-1:2];
    assign w_rword      = r_mem[w_cur_idx];

    // Address bits above the array size are ignored (wrap-around)
    assign w_unused_addr = ^req_addr[31:C_ADR_W];

    mem_lane_align u_align (
        .i_we      (w_cur_we),
        .i_funct3  (w_cur_funct3),
        .i_addr    (w_cur_addr[1:0]),
        .i_wdata   (w_cur_wdata),
        .i_rword   (w_rword),
        .o_be      (w_be),
        .o_wmerged (w_wmerged),
        .o_load    (w_load),
        .o_err     (w_err)
    );

    assign w_enter_resp = !rst &&
        (((r_state == IDLE) && req_valid && (LATENCY == 0)) ||
         ((r_state == WAIT) && (r_cnt == '0)));

    // Loads and errored accesses have zero byte-enables, so no write occurs
    assign w_commit = w_enter_resp && w_cur_we && (|w_be);

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_cur_idx] <= w_wmerged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_funct3    <= 3'b000;
            r_wdata     <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_addr   <= req_addr[C_ADR_W-1:0];
                        r_funct3 <= req_funct3;
                        r_wdata  <= req_wdata;
                        if (LATENCY == 0) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rdata     <= w_load;
                            r_err       <= w_err;
                        end else begin
                            r_cnt   <= C_CNT_INIT;
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= w_load;
                        r_err       <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == IDLE) && !rst;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule : data_mem_responder

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder (LATENCY=2).
//               Table of load/store vectors with a response scoreboard,
//               plus back-pressure and mid-operation reset sequences.
// Config      : MISALIGN_TRAP_EN selects the expected misaligned behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wdata, input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = we; v.addr = addr; v.f3 = f3; v.wdata = wdata;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    // Drive one request; returns after the acceptance edge (req_valid dropped)
    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_tests++; n_fail++;
            $display("FAIL req_ready_timeout: got 0, expected 1");
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    // Wait for rsp_valid counting negedge samples after acceptance
    task automatic wait_rsp(input string name, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 50);
        chk({name, "_latency"}, 32'(lat), 32'(LAT + 1));
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s_scoreboard_empty: got response, expected none", name);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_rdata"}, rsp_rdata, e.rdata);
            chk({name, "_err"}, {31'h0, rsp_err}, {31'h0, e.err});
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic txn(input string name, input logic we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wdata,
                       input logic [31:0] er, input logic ee);
        exp_t e;
        int   lat;
        drive_req(we, addr, f3, wdata);
        e.rdata = er; e.err = ee;
        sb_q.push_back(e);
        wait_rsp(name, lat);
        pop_check(name);
        release_rsp();
    endtask

    initial begin
        int lat;
        logic [31:0] hold_d;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_funct3 = 3'b000; req_wdata = 32'h0; rsp_ready = 1'b0;

        // Vector table
        add(1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0);           // sw
        add(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);           // lw
        add(0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 0);           // lb
        add(0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 0);           // lbu
        add(0, 32'h10, 3'b001, 32'h0, 32'hFFFFBEEF, 0);           // lh
        add(0, 32'h12, 3'b101, 32'h0, 32'h0000DEAD, 0);           // lhu
        add(0, 32'h12, 3'b000, 32'h0, 32'hFFFFFFAD, 0);           // lb lane 2
`ifdef MISALIGN_TRAP_EN
        add(0, 32'h12, 3'b010, 32'h0, 32'h0, 1);                  // lw misaligned
`else
        add(0, 32'h12, 3'b010, 32'h0, 32'hDEADBEEF, 0);
`endif
        add(0, 32'h10, 3'b011, 32'h0, 32'h0, 1);                  // bad load f3
        add(0, 32'h10, 3'b110, 32'h0, 32'h0, 1);                  // bad load f3
        add(1, 32'h10, 3'b100, 32'h11111111, 32'h0, 1);           // bad store f3
        add(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);           // unchanged
        add(1, 32'h11, 3'b000, 32'h000000AA, 32'h0, 0);           // sb
        add(0, 32'h10, 3'b010, 32'h0, 32'hDEADAAEF, 0);
        add(0, 32'h1010, 3'b010, 32'h0, 32'hDEADAAEF, 0);         // wrap
        add(1, 32'h14, 3'b010, 32'h0, 32'h0, 0);
        add(1, 32'h16, 3'b001, 32'hFFFF1234, 32'h0, 0);           // sh upper
        add(0, 32'h14, 3'b010, 32'h0, 32'h12340000, 0);
`ifdef MISALIGN_TRAP_EN
        add(0, 32'h11, 3'b101, 32'h0, 32'h0, 1);
        add(1, 32'h13, 3'b001, 32'h0000FFFF, 32'h0, 1);
        add(0, 32'h10, 3'b010, 32'h0, 32'hDEADAAEF, 0);
`else
        add(0, 32'h11, 3'b101, 32'h0, 32'h0000AAEF, 0);
        add(1, 32'h13, 3'b001, 32'h0000FFFF, 32'h0, 0);
        add(0, 32'h10, 3'b010, 32'h0, 32'hFFFFAAEF, 0);
`endif
        add(1, 32'h20, 3'b010, 32'h0, 32'h0, 0);
        add(1, 32'h24, 3'b010, 32'h0, 32'h0, 0);

        // Reset state
        #12;
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);

        foreach (vecs[i]) begin
            txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].f3,
                vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Back-pressure: hold rsp_ready low for 5 cycles on a load
        drive_req(0, 32'h14, 3'b010, 32'h0);
        wait_rsp("bp", lat);
        hold_d = 32'h12340000;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid_hold", {31'h0, rsp_valid}, 32'h1);
            chk("bp_rdata_hold", rsp_rdata, hold_d);
            chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
            @(negedge clk);
        end
        release_rsp();
        @(negedge clk);
        chk("bp_valid_drop", {31'h0, rsp_valid}, 32'h0);
        chk("bp_req_ready_back", {31'h0, req_ready}, 32'h1);

        // Reset during WAIT on an uncommitted store
        drive_req(1, 32'h20, 3'b010, 32'h12345678);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'h0, rsp_valid}, 32'h0);
        chk("midrst_rdata", rsp_rdata, 32'h0);
        chk("midrst_err", {31'h0, rsp_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        txn("after_midrst", 0, 32'h20, 3'b010, 32'h0, 32'h0, 0);

        // Reset while in RESP: the store already committed must persist
        drive_req(1, 32'h24, 3'b010, 32'hCAFEF00D);
        wait_rsp("resprst", lat);
        rst = 1'b1;
        #1;
        chk("resprst_valid", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        txn("after_resprst", 0, 32'h24, 3'b010, 32'h0, 32'hCAFEF00D, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_data_mem_responder

`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Data-memory responder: the memory end of the core's load/store interface. It accepts one load or store request at a time over a valid/ready handshake. After a configurable wait-state latency it performs RISC-V byte/half/word access with lane steering and sign/zero extension. It returns the result over a second valid/ready handshake. It sits between the core's memory port and a word-organised on-chip RAM array held inside the block.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
LATENCY, 2, wait-state cycles between request acceptance and rsp_valid rising, minus one; 0 is legal

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_funct3  input  3  RISC-V load/store funct3
req_wdata  input  32  store data, right-aligned
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  32  load result after extension; 0 for stores and errors
rsp_err  output  1  invalid funct3, or misaligned access when the trap feature is compiled in

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. req_ready=1 once rst deasserts. The array is not reset.
- FSM has three states: IDLE, WAIT and RESP. req_ready=1 only in IDLE; only one request is outstanding.
- IDLE: when req_valid && req_ready, capture we/addr/funct3/wdata.
  - LATENCY=0: go to RESP.
  - Otherwise: load counter with LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, go to RESP.
- Timing: rsp_valid rises LATENCY+1 cycles after the acceptance edge.
- Transition into RESP, same edge:
  - The store is committed to the array.
  - rsp_rdata/rsp_err are registered.
  - Both outputs hold stable while rsp_valid && !rsp_ready.
- RESP: on rsp_ready, go to IDLE with rsp_valid=0. A new request is accepted no earlier than the cycle after.
- Word index is addr[$clog2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4. The byte lane is addr[1:0].
- Loads:
  - 000 lb: sign-extend byte at the lane.
  - 001 lh: sign-extend half at lane addr[1].
  - 010 lw: full word.
  - 100 lbu / 101 lhu: zero-extend.
- Stores:
  - 000 sb: write wdata[7:0] to the selected byte.
  - 001 sh: write wdata[15:0] to the selected half.
  - 010 sw: write the full word.
  - Other bytes are untouched. rsp_rdata=0.
- Invalid funct3 (011 for loads; 011, 1xx for stores; 110/111 for loads): rsp_err=1, rsp_rdata=0, no write, same latency.
- Reset mid-operation (WAIT or RESP): the captured request is dropped. A store not yet committed is never written; a committed store stays in the array.
- req_* inputs are ignored outside IDLE.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, gives rsp_err=1, rsp_rdata=0 and no write, with normal latency.
- Undefined: the address is forced aligned (half: addr[0] treated as 0; word: addr[1:0] treated as 0), the access proceeds, and rsp_err reflects only invalid funct3.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - The FSM state typedef (IDLE/WAIT/RESP).
- One combinational sub-module, mem_lane_align. Inputs: funct3, addr[1:0], wdata, the read word. Outputs:
  - the 4-bit byte-enable
  - the merged store word
  - the extended load value
  - the err flag

Test Plan:
- Reset, then sw 0xDEADBEEF to addr 0x10, then lw 0x10 with LATENCY=2 -> each rsp_valid rises 3 cycles after acceptance; the lw returns 0xDEADBEEF, err=0.
- After word 0x10=0xDEADBEEF: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
- sb 0x11 with wdata=0x000000AA over 0xDEADBEEF, then lw 0x10 -> 0xDEADAABE... corrected: the result is 0xDEADAAEF.
- Hold rsp_ready=0 for 5 cycles on a load -> rsp_valid and rsp_rdata stable throughout and req_ready=0. Raise rsp_ready -> next cycle rsp_valid=0, req_ready=1.
- lw 0x12 -> with MISALIGN_TRAP_EN: err=1, rdata=0. Without: returns the word at 0x10, err=0. funct3=011 -> err=1 in both builds.
- Assert rst while in WAIT on sw 0x20=0x12345678 (prior value 0) -> outputs clear immediately; a subsequent lw 0x20 returns 0.
